// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing defaults, coordinate types and sync helper
package vga_pkg;

    localparam int H_VISIBLE_DEF = 800;
    localparam int H_FRONT_DEF   = 40;
    localparam int H_SYNC_DEF    = 128;
    localparam int H_BACK_DEF    = 88;
    localparam int H_TOTAL_DEF   = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;

    localparam int V_VISIBLE_DEF = 600;
    localparam int V_FRONT_DEF   = 1;
    localparam int V_SYNC_DEF    = 4;
    localparam int V_BACK_DEF    = 23;
    localparam int V_TOTAL_DEF   = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    localparam int H_COORD_W = 11;
    localparam int V_COORD_W = 10;

    typedef logic [H_COORD_W-1:0] h_coord_t;
    typedef logic [V_COORD_W-1:0] v_coord_t;

    // Maps "pulse active" onto the pin level for the chosen polarity.
    function automatic logic sync_level(input logic active, input logic active_high);
        return active ~^ active_high;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - wrapping position counter for one screen axis
module vga_axis_counter #(
    parameter int TOTAL = 1056,
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             advance,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_next,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(TOTAL - 1);

    // >= rather than == so an out-of-range value recovers to 0 on the next advance.
    assign wrap = advance && (count >= LAST);

    // Next value is exposed so the top can register decodes aligned with the count.
    always_comb begin
        count_next = count;
        if (advance) begin
            count_next = (count >= LAST) ? '0 : count + WIDTH'(1);
        end
    end

    // Reset parks on the last position so the first advance lands on 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= LAST;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator with frame/vblank pulses
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE        = H_VISIBLE_DEF,
    parameter int H_FRONT          = H_FRONT_DEF,
    parameter int H_SYNC           = H_SYNC_DEF,
    parameter int H_BACK           = H_BACK_DEF,
    parameter int V_VISIBLE        = V_VISIBLE_DEF,
    parameter int V_FRONT          = V_FRONT_DEF,
    parameter int V_SYNC           = V_SYNC_DEF,
    parameter int V_BACK           = V_BACK_DEF,
    parameter bit SYNC_ACTIVE_HIGH = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_pix_en,
    output logic [H_COORD_W-1:0] o_h_coord,
    output logic [V_COORD_W-1:0] o_v_coord,
    output logic                 o_disp_enbl,
    output logic                 o_hsync,
    output logic                 o_vsync,
    output logic                 o_frame_start,
    output logic                 o_vblank_start,
    output logic [15:0]          o_frame_cnt
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam h_coord_t H_VIS_END = h_coord_t'(H_VISIBLE);
    localparam h_coord_t HS_FIRST  = h_coord_t'(H_VISIBLE + H_FRONT);
    localparam h_coord_t HS_LAST   = h_coord_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam v_coord_t V_VIS_END = v_coord_t'(V_VISIBLE);
    localparam v_coord_t VS_FIRST  = v_coord_t'(V_VISIBLE + V_FRONT);
    localparam v_coord_t VS_LAST   = v_coord_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    h_coord_t h_next;
    v_coord_t v_next;
    logic     h_wrap;
    logic     v_wrap;
    logic     hs_active;
    logic     vs_active;
    logic     at_origin;
    logic     at_vblank;

    vga_axis_counter #(
        .TOTAL (H_TOTAL),
        .WIDTH (H_COORD_W)
    ) u_h_counter (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .advance    (i_pix_en),
        .count      (o_h_coord),
        .count_next (h_next),
        .wrap       (h_wrap)
    );

    vga_axis_counter #(
        .TOTAL (V_TOTAL),
        .WIDTH (V_COORD_W)
    ) u_v_counter (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .advance    (i_pix_en && h_wrap),
        .count      (o_v_coord),
        .count_next (v_next),
        .wrap       (v_wrap)
    );

    // Decode the position being loaded so registered flags line up with the coordinates.
    always_comb begin
        hs_active = (h_next >= HS_FIRST) && (h_next <= HS_LAST);
        vs_active = (v_next >= VS_FIRST) && (v_next <= VS_LAST);
        at_origin = (h_next == '0) && (v_next == '0);
        at_vblank = (h_next == '0) && (v_next == V_VIS_END);
    end

    // Display flags follow the strobe; the event pulses last one clock only.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_disp_enbl    <= 1'b0;
            o_hsync        <= sync_level(1'b0, SYNC_ACTIVE_HIGH);
            o_vsync        <= sync_level(1'b0, SYNC_ACTIVE_HIGH);
            o_frame_start  <= 1'b0;
            o_vblank_start <= 1'b0;
            o_frame_cnt    <= '0;
        end else begin
            o_frame_start  <= 1'b0;
            o_vblank_start <= 1'b0;
            if (i_pix_en) begin
                o_disp_enbl    <= (h_next < H_VIS_END) && (v_next < V_VIS_END);
                o_hsync        <= sync_level(hs_active, SYNC_ACTIVE_HIGH);
                o_vsync        <= sync_level(vs_active, SYNC_ACTIVE_HIGH);
                o_frame_start  <= at_origin;
                o_vblank_start <= at_vblank;
                if (at_origin) begin
                    o_frame_cnt <= o_frame_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // full-size timing instance
    logic        rst_d = 1'b1, en_d = 1'b0;
    logic [10:0] h_d;
    logic [9:0]  v_d;
    logic        de_d, hs_d, vs_d, fs_d, vb_d;
    logic [15:0] fc_d;

    // shortened timing: H 16+2+4+2=24, V 8+1+2+1=12
    logic        rst_s = 1'b1, en_s = 1'b0;
    logic [10:0] h_s;
    logic [9:0]  v_s;
    logic        de_s, hs_s, vs_s, fs_s, vb_s;
    logic [15:0] fc_s;

    // one-pixel frame, used to roll the frame counter over quickly
    logic        rst_w = 1'b1, en_w = 1'b0;
    logic [10:0] h_w;
    logic [9:0]  v_w;
    logic        de_w, hs_w, vs_w, fs_w, vb_w;
    logic [15:0] fc_w;

    vga_timing_gen dut_d (
        .i_clk(clk), .i_rst_n(rst_d), .i_pix_en(en_d),
        .o_h_coord(h_d), .o_v_coord(v_d), .o_disp_enbl(de_d),
        .o_hsync(hs_d), .o_vsync(vs_d), .o_frame_start(fs_d),
        .o_vblank_start(vb_d), .o_frame_cnt(fc_d)
    );

    vga_timing_gen #(
        .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
        .V_VISIBLE(8),  .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .SYNC_ACTIVE_HIGH(1'b1)
    ) dut_s (
        .i_clk(clk), .i_rst_n(rst_s), .i_pix_en(en_s),
        .o_h_coord(h_s), .o_v_coord(v_s), .o_disp_enbl(de_s),
        .o_hsync(hs_s), .o_vsync(vs_s), .o_frame_start(fs_s),
        .o_vblank_start(vb_s), .o_frame_cnt(fc_s)
    );

    vga_timing_gen #(
        .H_VISIBLE(1), .H_FRONT(0), .H_SYNC(0), .H_BACK(0),
        .V_VISIBLE(1), .V_FRONT(0), .V_SYNC(0), .V_BACK(0),
        .SYNC_ACTIVE_HIGH(1'b1)
    ) dut_w (
        .i_clk(clk), .i_rst_n(rst_w), .i_pix_en(en_w),
        .o_h_coord(h_w), .o_v_coord(v_w), .o_disp_enbl(de_w),
        .o_hsync(hs_w), .o_vsync(vs_w), .o_frame_start(fs_w),
        .o_vblank_start(vb_w), .o_frame_cnt(fc_w)
    );

    // reference position for the shortened instance
    int eh, ev, ecnt;
    logic efs, evb;

    function automatic void model_step();
        efs = 1'b0;
        evb = 1'b0;
        if (eh == 23) begin
            eh = 0;
            ev = (ev == 11) ? 0 : ev + 1;
        end else begin
            eh = eh + 1;
        end
        if (eh == 0 && ev == 0) begin
            efs  = 1'b1;
            ecnt = ecnt + 1;
        end
        if (eh == 0 && ev == 8) evb = 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        rst_d = 1'b0; rst_s = 1'b0; rst_w = 1'b0;
        tick();
        tick();
        n_checks++;
        if (h_d !== 11'd1055 || v_d !== 10'd627) begin
            n_fail++;
            $display("FAIL reset_coord: got (%0d,%0d) want (1055,627)", h_d, v_d);
        end
        n_checks++;
        if ({de_d, hs_d, vs_d, fs_d, vb_d} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got de/hs/vs/fs/vb=%b want 00000", {de_d, hs_d, vs_d, fs_d, vb_d});
        end
        n_checks++;
        if (fc_d !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %0d want 0", fc_d);
        end
        n_checks++;
        if (h_s !== 11'd23 || v_s !== 10'd11) begin
            n_fail++;
            $display("FAIL reset_coord_small: got (%0d,%0d) want (23,11)", h_s, v_s);
        end
    endtask

    task automatic test_first_strobe();
        rst_d = 1'b1;
        tick();
        en_d = 1'b1;
        tick();
        en_d = 1'b0;
        n_checks++;
        if (h_d !== 11'd0 || v_d !== 10'd0 || de_d !== 1'b1) begin
            n_fail++;
            $display("FAIL first_strobe_pos: got (%0d,%0d) de=%b want (0,0) de=1", h_d, v_d, de_d);
        end
        n_checks++;
        if (fs_d !== 1'b1 || fc_d !== 16'd1 || hs_d !== 1'b0 || vs_d !== 1'b0) begin
            n_fail++;
            $display("FAIL first_strobe_evt: got fs=%b cnt=%0d hs=%b vs=%b want 1 1 0 0", fs_d, fc_d, hs_d, vs_d);
        end
        tick();
        n_checks++;
        if (fs_d !== 1'b0 || h_d !== 11'd0 || fc_d !== 16'd1) begin
            n_fail++;
            $display("FAIL first_strobe_hold: got fs=%b h=%0d cnt=%0d want 0 0 1", fs_d, h_d, fc_d);
        end
    endtask

    task automatic test_line();
        int h = 0;
        int v = 0;
        en_d = 1'b1;
        for (int i = 0; i < 1056; i++) begin
            tick();
            h = h + 1;
            if (h == 1056) begin
                h = 0;
                v = v + 1;
            end
            n_checks++;
            if (h_d !== 11'(h) || v_d !== 10'(v)) begin
                n_fail++;
                $display("FAIL line_pos: got (%0d,%0d) want (%0d,%0d)", h_d, v_d, h, v);
            end
            n_checks++;
            if (hs_d !== (h >= 840 && h <= 967) || de_d !== (h < 800) || vs_d !== 1'b0) begin
                n_fail++;
                $display("FAIL line_flags at h=%0d: got hs=%b de=%b vs=%b", h, hs_d, de_d, vs_d);
            end
        end
        en_d = 1'b0;
    endtask

    task automatic test_full_frame();
        int fs_seen = 0;
        int vb_seen = 0;
        rst_s = 1'b1;
        eh = 23; ev = 11; ecnt = 0;
        tick();
        en_s = 1'b1;
        for (int i = 0; i < 289; i++) begin
            tick();
            model_step();
            if (fs_s === 1'b1) fs_seen++;
            if (vb_s === 1'b1) vb_seen++;
            n_checks++;
            if (h_s !== 11'(eh) || v_s !== 10'(ev) || fc_s !== 16'(ecnt)) begin
                n_fail++;
                $display("FAIL frame_pos: got (%0d,%0d) cnt=%0d want (%0d,%0d) cnt=%0d", h_s, v_s, fc_s, eh, ev, ecnt);
            end
            n_checks++;
            if (de_s !== (eh < 16 && ev < 8) || hs_s !== (eh >= 18 && eh <= 21) ||
                vs_s !== (ev >= 9 && ev <= 10) || fs_s !== efs || vb_s !== evb) begin
                n_fail++;
                $display("FAIL frame_flags at (%0d,%0d): got de=%b hs=%b vs=%b fs=%b vb=%b", eh, ev, de_s, hs_s, vs_s, fs_s, vb_s);
            end
        end
        en_s = 1'b0;
        n_checks++;
        if (fs_seen != 2 || vb_seen != 1 || fc_s !== 16'd2) begin
            n_fail++;
            $display("FAIL frame_pulses: got fs=%0d vb=%0d cnt=%0d want 2 1 2", fs_seen, vb_seen, fc_s);
        end
    endtask

    task automatic test_quarter_rate();
        logic strobe;
        for (int c = 0; c < 1200; c++) begin
            strobe = (c % 4 == 0);
            en_s = strobe;
            tick();
            if (strobe) begin
                model_step();
            end else begin
                efs = 1'b0;
                evb = 1'b0;
            end
            n_checks++;
            if (h_s !== 11'(eh) || v_s !== 10'(ev) || fc_s !== 16'(ecnt)) begin
                n_fail++;
                $display("FAIL quarter_pos: got (%0d,%0d) cnt=%0d want (%0d,%0d) cnt=%0d", h_s, v_s, fc_s, eh, ev, ecnt);
            end
            n_checks++;
            if (de_s !== (eh < 16 && ev < 8) || hs_s !== (eh >= 18 && eh <= 21) ||
                vs_s !== (ev >= 9 && ev <= 10) || fs_s !== efs || vb_s !== evb) begin
                n_fail++;
                $display("FAIL quarter_flags cycle %0d: got de=%b hs=%b vs=%b fs=%b vb=%b", c, de_s, hs_s, vs_s, fs_s, vb_s);
            end
        end
        en_s = 1'b0;
    endtask

    task automatic test_async_reset();
        rst_s = 1'b0;
        tick();
        rst_s = 1'b1;
        tick();
        en_s = 1'b1;
        for (int i = 0; i < 131; i++) tick();
        n_checks++;
        if (h_s !== 11'd10 || v_s !== 10'd5 || de_s !== 1'b1) begin
            n_fail++;
            $display("FAIL midframe_pos: got (%0d,%0d) de=%b want (10,5) de=1", h_s, v_s, de_s);
        end
        #2;
        rst_s = 1'b0;
        #1;
        n_checks++;
        if (h_s !== 11'd23 || v_s !== 10'd11 || fc_s !== 16'd0 ||
            {de_s, hs_s, vs_s, fs_s, vb_s} !== 5'b0) begin
            n_fail++;
            $display("FAIL async_reset: got (%0d,%0d) cnt=%0d flags=%b want (23,11) 0 00000",
                     h_s, v_s, fc_s, {de_s, hs_s, vs_s, fs_s, vb_s});
        end
        tick();
        rst_s = 1'b1;
        tick();
        n_checks++;
        if (h_s !== 11'd0 || v_s !== 10'd0 || fs_s !== 1'b1 || fc_s !== 16'd1 || de_s !== 1'b1) begin
            n_fail++;
            $display("FAIL restart: got (%0d,%0d) fs=%b cnt=%0d de=%b want (0,0) 1 1 1", h_s, v_s, fs_s, fc_s, de_s);
        end
        en_s = 1'b0;
    endtask

    task automatic test_frame_cnt_wrap();
        rst_w = 1'b1;
        tick();
        en_w = 1'b1;
        for (int i = 0; i < 65535; i++) tick();
        n_checks++;
        if (fc_w !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL cnt_max: got %h want ffff", fc_w);
        end
        tick();
        n_checks++;
        if (fc_w !== 16'h0000) begin
            n_fail++;
            $display("FAIL cnt_wrap: got %h want 0000", fc_w);
        end
        n_checks++;
        if (h_w !== 11'd0 || v_w !== 10'd0 || {de_w, hs_w, vs_w, fs_w, vb_w} !== 5'b10010) begin
            n_fail++;
            $display("FAIL cnt_wrap_glitch: got (%0d,%0d) flags=%b want (0,0) 10010",
                     h_w, v_w, {de_w, hs_w, vs_w, fs_w, vb_w});
        end
        tick();
        n_checks++;
        if (fc_w !== 16'h0001) begin
            n_fail++;
            $display("FAIL cnt_after_wrap: got %h want 0001", fc_w);
        end
        en_w = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_strobe();
        test_line();
        test_full_frame();
        test_quarter_rate();
        test_async_reset();
        test_frame_cnt_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_VISIBLE, 800, active pixels per line.
REQ-002 Parameter H_FRONT, 40; H_SYNC, 128; H_BACK, 88; these are horizontal porch and sync widths, with H_TOTAL = 1056.
REQ-003 Parameter V_VISIBLE, 600, active lines per frame.
REQ-004 Parameter V_FRONT, 1; V_SYNC, 4; V_BACK, 23; these are vertical porch and sync widths, with V_TOTAL = 628.
REQ-005 Parameter SYNC_ACTIVE_HIGH, 1; sync polarity, where 1 means the pulse is high.
REQ-006 i_clk  input  1  system clock; all state changes on the rising edge.
REQ-007 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-008 i_pix_en  input  1  pixel-rate strobe; one high cycle advances one pixel.
REQ-009 o_h_coord  output  11  horizontal counter, 0..H_TOTAL-1.
REQ-010 o_v_coord  output  10  vertical counter, 0..V_TOTAL-1.
REQ-011 o_disp_enbl  output  1  high when h < H_VISIBLE and v < V_VISIBLE.
REQ-012 o_hsync, o_vsync  output  1 each  sync pulses at SYNC_ACTIVE_HIGH polarity.
REQ-013 o_frame_start  output  1  single-clk pulse on entry to (0,0).
REQ-014 o_vblank_start  output  1  single-clk pulse on entry to (0,V_VISIBLE); the game-logic update window.
REQ-015 o_frame_cnt  output  16  completed-frame counter.

Function
REQ-016 Counters SHALL change only in cycles with i_pix_en=1; with i_pix_en=0 all outputs hold, and the pulse outputs are 0.
REQ-017 h SHALL increment by 1 per strobe and wrap from H_TOTAL-1 to 0; on that wrap v increments.
REQ-018 v SHALL wrap from V_TOTAL-1 to 0 on the strobe where h wraps with v = V_TOTAL-1.
REQ-019 All outputs SHALL be registered.
REQ-020 o_disp_enbl, o_hsync and o_vsync SHALL be decoded from the next counter value, so they are cycle-aligned with o_h_coord/o_v_coord (zero relative latency).
REQ-021 hsync SHALL be active for h in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], i.e. 840..967.
REQ-022 vsync SHALL be active for v in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1], i.e. 601..604, for full lines.
REQ-023 o_frame_start SHALL be high for exactly one i_clk cycle: the cycle after the strobe that loads (0,0).
REQ-024 o_vblank_start SHALL be high for exactly one i_clk cycle: the cycle after the strobe that loads (0,600).
REQ-025 o_frame_cnt SHALL increment by 1 in the same cycle o_frame_start asserts, and wrap from 16'hFFFF to 0.
REQ-026 Counter arithmetic SHALL be unsigned; a counter value >= its total is unreachable, and if one occurs the counter wraps to 0 on the next strobe.
REQ-027 i_pix_en held high continuously SHALL be legal: one pixel per clk, with identical sequencing.

Reset
REQ-028 While i_rst_n=0, outputs SHALL be: h=H_TOTAL-1, v=V_TOTAL-1, o_disp_enbl=0, syncs inactive, both pulses 0, o_frame_cnt=0.
REQ-029 Reset assertion SHALL take effect immediately, without a clock edge, including mid-frame.
REQ-030 After release, the first i_pix_en strobe SHALL load (0,0) with o_disp_enbl=1 and o_frame_start=1.
REQ-031 The increment on that first strobe SHALL bring o_frame_cnt to 1.

Structure
REQ-032 Timing defaults, H_TOTAL/V_TOTAL and the coordinate widths SHALL live in shared package vga_pkg, which the pixel renderer also uses.
REQ-033 The horizontal and vertical counters SHALL be two instances of sub-module vga_axis_counter (parameters TOTAL and WIDTH; inputs advance; outputs count and wrap).

Verification
REQ-034 Reset then one strobe -> (0,0), disp=1, frame_start one clk, frame_cnt=1, hsync=vsync=inactive.
REQ-035 Strobe continuously across a line -> hsync asserts on the cycle h=840 and deasserts at h=968; disp=0 from h=800; at h=1055->0, v increments by 1.
REQ-036 Run a full frame -> vsync high for lines 601..604 only; vblank_start one clk at (0,600); (1055,627)->(0,0) with frame_start and frame_cnt=2.
REQ-037 i_pix_en toggling 1-of-4 -> identical coordinate sequence at 1/4 rate; pulses still exactly one clk; outputs hold between strobes.
REQ-038 Assert i_rst_n=0 asynchronously at (500,300) -> outputs reach reset values before the next clock edge; the frame restarts cleanly after release.
REQ-039 Force frame_cnt near 16'hFFFF by running 65536 frames (or a shortened-timing build) -> wraps to 0 with no glitch on the other outputs.
